// File: rtl/pif_regfile_if.sv
// Byte-level link between the I2C slave engine and the register file.
// master = I2C slave side, slave = register file side.
interface pif_regfile_if;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       XFER_STOP;
  logic       TX_REQ;
  logic [7:0] TX_DATA;
  logic       TX_VALID;

  modport master (
    output RX_VALID, RX_DATA, XFER_STOP, TX_REQ,
    input  TX_DATA, TX_VALID
  );

  modport slave (
    input  RX_VALID, RX_DATA, XFER_STOP, TX_REQ,
    output TX_DATA, TX_VALID
  );
endinterface

// File: rtl/pif_regfile.sv
// I2C-fed register file: tagged address/data bytes, read-back, error counter.
// Optional build macro PIF_AUTOINC_EN: pointer post-increments on D_ADDR bytes in ARMED and served reads.
module pif_regfile #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 6
) (
  input  logic                CLK,
  input  logic                GSRn,
  pif_regfile_if.slave        pif,
  output logic [NREGS*DW-1:0] REG_FLAT,
  output logic                LED_SYNC,
  output logic                WR_STROBE,
  output logic [7:0]          ERR_CNT
);

  typedef enum logic {IDLE, ARMED} state_t;
  typedef enum logic [1:0] {
    A_ADDR = 2'b00,
    D_ADDR = 2'b01,
    TAG_R2 = 2'b10,
    TAG_R3 = 2'b11
  } tag_t;

  state_t         state_q, state_d;
  logic [5:0]     ptr_q, ptr_d;
  logic [DW-1:0]  regs_q [NREGS];
  logic [DW-1:0]  regs_d [NREGS];
  logic [7:0]     err_q, err_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           wr_strobe_q, wr_strobe_d;

  logic [5:0]     payload;
  tag_t           tag;
  logic [5:0]     rd_data;
  logic           ptr_hit;
  logic           wr_en;
  logic [1:0]     err_inc;
  logic [8:0]     err_sum;

  assign payload = pif.RX_DATA[5:0];
  assign tag     = tag_t'(pif.RX_DATA[7:6]);

  always_comb begin
    // Out-of-range pointer reads as all ones
    rd_data = '1;
    ptr_hit = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (ptr_q == 6'(i)) begin
        rd_data = 6'(regs_q[i]);
        ptr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_en       = 1'b0;
    err_inc     = '0;

    if (pif.RX_VALID) begin
      case (tag)
        A_ADDR: begin
          ptr_d   = payload;
          state_d = ARMED;
        end
        D_ADDR: begin
          if (state_q == ARMED) begin
            if (ptr_hit) begin
              wr_en       = 1'b1;
              wr_strobe_d = 1'b1;
            end else begin
              err_inc = err_inc + 2'd1;
            end
`ifdef PIF_AUTOINC_EN
            ptr_d = ptr_q + 6'd1;
`endif
          end else begin
            err_inc = err_inc + 2'd1;
          end
        end
        default: err_inc = err_inc + 2'd1;
      endcase
      // A read request colliding with a received byte is dropped and counted
      if (pif.TX_REQ) err_inc = err_inc + 2'd1;
    end else if (pif.TX_REQ) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {D_ADDR, rd_data};
`ifdef PIF_AUTOINC_EN
      ptr_d = ptr_q + 6'd1;
`endif
    end

    // Stop applies after the coincident byte was judged under the old state
    if (pif.XFER_STOP) state_d = IDLE;

    err_sum = {1'b0, err_q} + 9'(err_inc);
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && ptr_q == 6'(i)) regs_d[i] = DW'(payload);
    end
  end

  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      err_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      wr_strobe_q <= wr_strobe_d;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) REG_FLAT[i*DW +: DW] = regs_q[i];
  end

  generate
    if (NREGS > 2) begin : g_led
      assign LED_SYNC = regs_q[2][0];
    end else begin : g_no_led
      assign LED_SYNC = 1'b0;
    end
  endgenerate

  assign pif.TX_DATA  = tx_data_q;
  assign pif.TX_VALID = tx_valid_q;
  assign WR_STROBE    = wr_strobe_q;
  assign ERR_CNT      = err_q;

endmodule

// File: doc/pif_regfile.md
PIF_REGFILE -- requirements
Module: pif_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 8, number of implemented 6-bit registers (1..64).
REQ-002 SHALL have parameter DW, default 6 (`I2C_DATA_BITS), register payload width.
REQ-003 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port GSRn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_VALID  input  1  one-cycle strobe, byte received from the I2C slave.
REQ-006 SHALL have port RX_DATA  input  8  received byte, [7:6] tag, [5:0] payload.
REQ-007 SHALL have port XFER_STOP  input  1  one-cycle strobe, I2C stop condition detected.
REQ-008 SHALL have port TX_REQ  input  1  one-cycle strobe, slave requests a read byte.
REQ-009 SHALL have port TX_DATA  output  8  read byte for the slave.
REQ-010 SHALL have port TX_VALID  output  1  one-cycle strobe qualifying TX_DATA.
REQ-011 SHALL have port REG_FLAT  output  NREGS*DW  all registers, reg[n] at [n*DW +: DW].
REQ-012 SHALL have port LED_SYNC  output  1  reg[2] bit 0; 0 = alternating LEDs, 1 = synchronous LEDs.
REQ-013 SHALL have port WR_STROBE  output  1  one-cycle pulse after every accepted register write.
REQ-014 SHALL have port ERR_CNT  output  8  count of rejected bytes and requests.

Function
REQ-015 SHALL decode tags as A_ADDR = 2'b00, D_ADDR = 2'b01, 2'b10 and 2'b11 reserved.
REQ-016 SHALL implement FSM states IDLE and ARMED. Reset sets IDLE. An A_ADDR byte moves IDLE->ARMED. An A_ADDR byte in ARMED stays ARMED. XFER_STOP moves ARMED->IDLE.
REQ-017 An A_ADDR byte SHALL load the 6-bit pointer with the payload, effective the next cycle, without modifying any register.
REQ-018 A D_ADDR byte in ARMED with pointer < NREGS SHALL write the payload to reg[pointer] and pulse WR_STROBE in the following cycle.
REQ-019 Write latency SHALL be 1: REG_FLAT and LED_SYNC show the new value in the cycle after RX_VALID.
REQ-020 A D_ADDR byte in ARMED with pointer >= NREGS SHALL write nothing and SHALL increment ERR_CNT.
REQ-021 A D_ADDR byte in IDLE SHALL write nothing and SHALL increment ERR_CNT.
REQ-022 A reserved-tag byte SHALL be ignored and SHALL increment ERR_CNT.
REQ-023 TX_REQ SHALL assert TX_VALID exactly 1 cycle later, in either state.
REQ-024 On that TX_VALID, TX_DATA SHALL be {D_ADDR, reg[pointer]} when pointer < NREGS, otherwise {D_ADDR, 6'h3F}.
REQ-025 When RX_VALID and TX_REQ coincide, the RX byte SHALL be processed, the TX_REQ dropped (no TX_VALID), and ERR_CNT incremented once.
REQ-026 When XFER_STOP coincides with RX_VALID, the byte SHALL be processed under the current state first, then the state becomes IDLE.
REQ-027 ERR_CNT SHALL saturate at 255 and never wrap.
REQ-028 The pointer SHALL be retained across XFER_STOP.
REQ-029 TX_DATA SHALL hold its last value while TX_VALID is low.

Reset
REQ-030 GSRn low SHALL immediately clear all registers, pointer, ERR_CNT, TX_DATA, TX_VALID and WR_STROBE to 0, and set the state to IDLE.
REQ-031 Reset mid-transaction SHALL abandon any pending TX_VALID or WR_STROBE; after release, a D_ADDR byte is rejected until an A_ADDR byte arrives.

Configuration
REQ-032 With PIF_AUTOINC_EN defined, each accepted or rejected D_ADDR byte in ARMED, and each served TX_REQ, SHALL increment the pointer modulo 64 (63 wraps to 0).
REQ-033 Without PIF_AUTOINC_EN, the pointer SHALL change only on A_ADDR bytes.

Verification
REQ-034 Reset, then RX bytes 0x02 and 0x41, then XFER_STOP -> reg[2]=1, LED_SYNC=1, one WR_STROBE pulse, ERR_CNT=0, state IDLE.
REQ-035 Bytes 0x07, 0x45, 0x46 with NREGS=8 and PIF_AUTOINC_EN -> reg[7]=5; the second write hits pointer 8 and is rejected; ERR_CNT=1.
REQ-036 Bytes 0x03, 0x6A, then TX_REQ -> TX_VALID one cycle later with TX_DATA=0x6A under PIF_AUTOINC_EN requires re-addressing to 0x03 first. Without the macro, TX_DATA=0x6A directly.
REQ-037 Stimulus: D_ADDR byte 0x41 in IDLE, reserved byte 0xC0, then RX_VALID coinciding with TX_REQ -> no writes, ERR_CNT=3, no TX_VALID.
REQ-038 Stimulus: 300 reserved bytes -> ERR_CNT=255. Then GSRn pulsed low mid-TX_REQ -> all outputs 0 and no TX_VALID.
REQ-039 Bytes 0x3F, then D_ADDR 0x40 with PIF_AUTOINC_EN -> rejected, ERR_CNT=1. Pointer wraps to 0. Next 0x55 writes reg[0]=0x15.
